// File: rtl/mono_rx_fifo_arbiter.sv
// Round-robin burst arbiter merging up to eight mono_data_rx channel FIFOs into one registered word stream.
// Optional MONO_RX_ARB_CHTAG_EN: replaces OUT_DATA[31:29] with the granted channel index.
module mono_rx_fifo_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic [NUM_CH-1:0]     CH_EN,
    input  logic [NUM_CH-1:0]     CH_FIFO_EMPTY,
    input  logic [32*NUM_CH-1:0]  CH_FIFO_DATA,
    output logic [NUM_CH-1:0]     CH_FIFO_READ,
    input  logic                  OUT_READ,
    output logic                  OUT_EMPTY,
    output logic [31:0]           OUT_DATA,
    output logic                  GRANT_VALID,
    output logic [2:0]            GRANT_IDX
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_grant_idx;
    logic [7:0]  r_burst_cnt;
    logic        r_out_empty;
    logic [31:0] r_out_data;

    logic [7:0]       w_elig8;
    logic [7:0][31:0] w_data_arr;
    logic [31:0]      w_head;
    logic [31:0]      w_word;
    logic             w_found;
    logic [2:0]       w_next;
    logic [2:0]       w_cand;
    logic             w_pop;
    logic             w_out_pop;
    logic             w_burst_last;
    logic [7:0]       w_rd8;

    // Channel vectors are widened to 8 entries so a 3-bit index is always in range.
    always_comb begin
        w_elig8    = 8'(CH_EN & ~CH_FIFO_EMPTY);
        w_data_arr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_data_arr[i] = CH_FIFO_DATA[32*i +: 32];
        end
    end

    assign w_head = w_data_arr[r_grant_idx];

`ifdef MONO_RX_ARB_CHTAG_EN
    assign w_word = {r_grant_idx, w_head[28:0]};
`else
    assign w_word = w_head;
`endif

    // Search starts one past the last grant so every channel gets its turn.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_grant_idx;
        w_cand  = r_grant_idx;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = 3'((int'(r_grant_idx) + k) % NUM_CH);
            if (!w_found && w_elig8[w_cand]) begin
                w_found = 1'b1;
                w_next  = w_cand;
            end
        end
    end

    assign w_out_pop    = OUT_READ && !r_out_empty;
    assign w_pop        = (r_state == ST_GRANT) && w_elig8[r_grant_idx] &&
                          (r_out_empty || OUT_READ);
    assign w_burst_last = (r_burst_cnt + 8'd1) == 8'(MAX_BURST);
    assign w_rd8        = w_pop ? (8'd1 << r_grant_idx) : 8'd0;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= 3'(NUM_CH - 1);
            r_burst_cnt <= 8'd0;
            r_out_empty <= 1'b1;
            r_out_data  <= 32'd0;
        end else begin
            if (w_pop) begin
                r_out_data  <= w_word;
                r_out_empty <= 1'b0;
            end else if (w_out_pop) begin
                r_out_empty <= 1'b1;
            end

            if (r_state == ST_IDLE) begin
                if (w_found) begin
                    r_state     <= ST_GRANT;
                    r_grant_idx <= w_next;
                    r_burst_cnt <= 8'd0;
                end
            end else begin
                if (w_pop) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                    if (w_burst_last) begin
                        r_state <= ST_IDLE;
                    end
                end else if (!w_elig8[r_grant_idx]) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign CH_FIFO_READ = w_rd8[NUM_CH-1:0];
    assign OUT_EMPTY    = r_out_empty;
    assign OUT_DATA     = r_out_data;
    assign GRANT_VALID  = (r_state == ST_GRANT);
    assign GRANT_IDX    = r_grant_idx;

endmodule

// File: doc/mono_rx_fifo_arbiter.md
# mono_rx_fifo_arbiter

Round-robin arbiter that merges the 32-bit output FIFOs of up to eight `mono_data_rx` channels into one word stream for the downstream FIFO/SiTCP path. It issues `FIFO_READ` pops to one granted channel at a time, in bursts of bounded length. A one-word registered output stage lets the block sustain one word per clock during a burst. It sits between the per-channel receivers and the top-level data FIFO, in the bus clock domain.

## Interface
- `NUM_CH`, 4: number of channels, 1..8.
- `MAX_BURST`, 16: maximum words per grant, 1..255.
- `BUS_CLK` in 1: clock; all logic rising-edge.
- `BUS_RST_N` in 1: reset, asynchronous assert, active-low.
- `CH_EN` in NUM_CH: per-channel enable mask; disabled channels are never granted.
- `CH_FIFO_EMPTY` in NUM_CH: channel FIFO empty flags, first-word-fall-through.
- `CH_FIFO_DATA` in 32*NUM_CH: channel head words; channel i occupies bits [32i+31:32i].
- `CH_FIFO_READ` out NUM_CH: one-hot pop strobe to the granted channel.
- `OUT_READ` in 1: downstream pop; ignored while `OUT_EMPTY`=1.
- `OUT_EMPTY` out 1: output word not valid.
- `OUT_DATA` out 32: output word, registered.
- `GRANT_VALID` out 1: a channel is currently granted.
- `GRANT_IDX` out 3: index of the granted or last-granted channel.

## Operation
- FSM states: IDLE and GRANT.
- **IDLE:**
  - A channel is eligible when `CH_EN[i]` is 1 and `CH_FIFO_EMPTY[i]` is 0.
  - If any channel is eligible, grant the first eligible index after `GRANT_IDX`, wrapping modulo NUM_CH.
  - On a grant, clear the burst counter and go to GRANT. Otherwise stay in IDLE.
- **GRANT, channel g:**
  - A pop happens when channel g is eligible and the output stage is free, i.e. `OUT_EMPTY`=1 or `OUT_READ`=1.
  - A pop asserts `CH_FIFO_READ[g]` combinationally, loads `CH_FIFO_DATA[g]` into `OUT_DATA` at the next edge, clears `OUT_EMPTY`, and increments the burst counter.
  - An output pop without a refill sets `OUT_EMPTY`=1.
- **Exit from GRANT to IDLE:**
  - A pop makes the burst counter reach MAX_BURST.
  - Channel g becomes ineligible (empty or disabled) in a cycle with no pop.
  - A pop in the last cycle before either condition still completes.
- Channel g is never popped in the cycle it goes ineligible.
- `CH_FIFO_READ` is never asserted in IDLE, and at most one bit is ever set.
- Round-robin fairness: a continuously non-empty enabled channel is granted within NUM_CH−1 intervening bursts.
- The burst counter is 8 bit.
- Words are never dropped or duplicated. Order within a channel is preserved.

## Timing
- Reset values:
  - FSM in IDLE.
  - `CH_FIFO_READ`=0, `OUT_EMPTY`=1, `OUT_DATA`=0.
  - `GRANT_VALID`=0, `GRANT_IDX`=NUM_CH−1, so that the first grant goes to channel 0.
- Latency from a channel going non-empty (arbiter idle) to `OUT_EMPTY`=0 is 2 cycles: grant edge, then capture edge.
- Throughput inside a burst is 1 word/cycle when `OUT_READ` is held high.
- Every grant change costs exactly one IDLE cycle.
- Simultaneous output pop and refill: the new word replaces the old one with `OUT_EMPTY` staying 0.
- Reset mid-burst:
  - Outputs return to reset values immediately.
  - A word held in the output stage is lost. This is the intended behaviour; reset flushes the readout.
- NUM_CH=1: channel 0 is regranted after each exit from GRANT, with one IDLE cycle between bursts.

## Configuration
- The macro is `MONO_RX_ARB_CHTAG_EN`.
- When defined: `OUT_DATA[31:29]` is overwritten with the granted channel index, and bits [28:0] are passed unchanged.
- When undefined: the word is passed unmodified.

## Test plan
- Reset with all channels empty -> `OUT_EMPTY`=1, `CH_FIFO_READ`=0, `GRANT_VALID`=0. Channel 2 loaded with 1 word -> `OUT_EMPTY`=0 two cycles later with that word, and `GRANT_IDX`=2.
- NUM_CH=4, MAX_BURST=4, channels 0..3 each holding 10 words, `OUT_READ` tied high -> grant order 0,1,2,3,0,… in 4-word bursts. Each grant change costs one cycle. All 40 words are output, in order per channel.
- Channel 1 holds 3 words and MAX_BURST=16 -> burst ends after 3 words with no extra `CH_FIFO_READ`, and the next eligible channel is granted.
- `OUT_READ` held low for 5 cycles mid-burst -> `CH_FIFO_READ` stays low and `OUT_DATA` stays stable. On release, the stream resumes with no gap and no duplicate.
- `CH_EN[0]` cleared while channel 0 is granted -> no further pops from channel 0, and the next grant goes to channel 1. `CH_EN`=0 with data present -> no grant.
- With `MONO_RX_ARB_CHTAG_EN` defined: word 0xFFFFFFFF from channel 5 -> `OUT_DATA`=0xBFFFFFFF. Without the macro -> 0xFFFFFFFF.
